// File: rtl/mat_pkg.sv
// Shared types for the matrix register bank: command opcodes, beat orientation and FSM states.
package mat_pkg;

    localparam int unsigned MAT_DEFAULT_DATA_W = 32;

    typedef enum logic [2:0] {
        LOAD      = 3'd0,
        STORE     = 3'd1,
        TRANSPOSE = 3'd2,
        XFLIP     = 3'd3,
        YFLIP     = 3'd4,
        CLEAR     = 3'd5
    } MatBankOp_t;

    typedef enum logic [0:0] {
        ROW = 1'b0,
        COL = 1'b1
    } MatDir_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_STORE = 2'd2
    } mat_state_t;

    // Ops that complete in the acceptance cycle without touching the beat streams.
    function automatic logic is_inplace_op(input MatBankOp_t op);
        return (op == TRANSPOSE) || (op == XFLIP) || (op == YFLIP) || (op == CLEAR);
    endfunction

endpackage

// File: rtl/mat_reg_store.sv
// One WIDTH x WIDTH matrix register: row/column beat write, in-place ops, combinational row/column read.
module mat_reg_store
    import mat_pkg::*;
#(
    parameter int unsigned WIDTH  = 128,
    parameter int unsigned DATA_W = MAT_DEFAULT_DATA_W,
    parameter int unsigned IDX_W  = $clog2(WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_wr_en,
    input  MatDir_t                 i_wr_dir,
    input  logic [IDX_W-1:0]        i_wr_idx,
    input  logic [WIDTH*DATA_W-1:0] i_wr_data,
    input  logic                    i_op_en,
    input  MatBankOp_t              i_op,
    input  MatDir_t                 i_rd_dir,
    input  logic [IDX_W-1:0]        i_rd_idx,
    output logic [WIDTH*DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [WIDTH][WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < WIDTH; i++)
                for (int unsigned j = 0; j < WIDTH; j++)
                    r_mem[i][j] <= '0;
        end else if (i_op_en) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                for (int unsigned j = 0; j < WIDTH; j++) begin
                    case (i_op)
                        TRANSPOSE: r_mem[i][j] <= r_mem[j][i];
                        XFLIP:     r_mem[i][j] <= r_mem[IDX_W'(WIDTH-1-i)][j];
                        YFLIP:     r_mem[i][j] <= r_mem[i][IDX_W'(WIDTH-1-j)];
                        CLEAR:     r_mem[i][j] <= '0;
                        default:   ;
                    endcase
                end
            end
        end else if (i_wr_en) begin
            for (int unsigned k = 0; k < WIDTH; k++) begin
                if (i_wr_dir == ROW)
                    r_mem[i_wr_idx][k] <= i_wr_data[k*DATA_W +: DATA_W];
                else
                    r_mem[k][i_wr_idx] <= i_wr_data[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        o_rd_data = '0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            if (i_rd_dir == ROW)
                o_rd_data[k*DATA_W +: DATA_W] = r_mem[i_rd_idx][k];
            else
                o_rd_data[k*DATA_W +: DATA_W] = r_mem[k][i_rd_idx];
        end
    end

endmodule

// File: rtl/mat_reg_bank.sv
// Bank of NUM_REGS matrix registers behind one command port, with streamed load/store
// beats and single-cycle in-place ops.
module mat_reg_bank
    import mat_pkg::*;
#(
    parameter int unsigned NUM_REGS = 4,
    parameter int unsigned WIDTH    = 128,
    parameter int unsigned DATA_W   = MAT_DEFAULT_DATA_W,
    parameter int unsigned REG_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
    parameter int unsigned IDX_W    = $clog2(WIDTH)
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  MatBankOp_t              cmd_op,
    input  logic [REG_W-1:0]        cmd_reg,
    input  MatDir_t                 cmd_dir,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH*DATA_W-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH*DATA_W-1:0] out_data,
    output logic                    out_last,
    output logic                    cmd_err
);

    localparam int unsigned BEAT_W = WIDTH * DATA_W;

    mat_state_t          r_state;
    mat_state_t          w_state_nxt;
    logic [IDX_W-1:0]    r_cnt;
    logic [REG_W-1:0]    r_reg;
    MatDir_t             r_dir;
    logic [BEAT_W-1:0]   r_out_data;
    logic                r_out_last;
    logic                r_cmd_err;

    logic                w_accept;
    logic                w_bad_reg;
    logic                w_load_beat;
    logic                w_store_beat;
    logic                w_last;
    logic [IDX_W-1:0]    w_cnt_nxt;
    logic [REG_W-1:0]    w_rd_reg;
    MatDir_t             w_rd_dir;
    logic [IDX_W-1:0]    w_rd_idx;
    logic [BEAT_W-1:0]   w_rd_data;
    logic [BEAT_W-1:0]   w_rd_all [NUM_REGS];
    logic [NUM_REGS-1:0] w_wr_en;
    logic [NUM_REGS-1:0] w_op_en;

    assign w_accept     = cmd_valid & cmd_ready;
    assign w_bad_reg    = {1'b0, cmd_reg} >= (REG_W+1)'(NUM_REGS);
    assign w_load_beat  = (r_state == ST_LOAD) & in_valid;
    assign w_store_beat = (r_state == ST_STORE) & out_ready;
    assign w_last       = (r_cnt == IDX_W'(WIDTH-1));
    assign w_cnt_nxt    = r_cnt + IDX_W'(1);

    // Read port serves the first store beat at acceptance, then prefetches the next beat.
    assign w_rd_reg = (r_state == ST_IDLE) ? cmd_reg : r_reg;
    assign w_rd_dir = (r_state == ST_IDLE) ? cmd_dir : r_dir;
    assign w_rd_idx = (r_state == ST_IDLE) ? '0 : w_cnt_nxt;

    always_comb begin
        w_rd_data = '0;
        w_wr_en   = '0;
        w_op_en   = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            if (w_rd_reg == REG_W'(r))
                w_rd_data = w_rd_all[r];
            w_wr_en[r] = w_load_beat & (r_reg == REG_W'(r));
            w_op_en[r] = w_accept & is_inplace_op(cmd_op) & (cmd_reg == REG_W'(r));
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        mat_reg_store #(
            .WIDTH  (WIDTH),
            .DATA_W (DATA_W),
            .IDX_W  (IDX_W)
        ) u_store (
            .clk       (clock),
            .rst_n     (reset_n),
            .i_wr_en   (w_wr_en[g]),
            .i_wr_dir  (r_dir),
            .i_wr_idx  (r_cnt),
            .i_wr_data (in_data),
            .i_op_en   (w_op_en[g]),
            .i_op      (cmd_op),
            .i_rd_dir  (w_rd_dir),
            .i_rd_idx  (w_rd_idx),
            .o_rd_data (w_rd_all[g])
        );
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && !w_bad_reg) begin
                    if (cmd_op == LOAD)       w_state_nxt = ST_LOAD;
                    else if (cmd_op == STORE) w_state_nxt = ST_STORE;
                end
            end
            ST_LOAD:  if (w_load_beat && w_last)  w_state_nxt = ST_IDLE;
            ST_STORE: if (w_store_beat && w_last) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= '0;
            r_reg      <= '0;
            r_dir      <= ROW;
            r_out_data <= '0;
            r_out_last <= 1'b0;
            r_cmd_err  <= 1'b0;
        end else begin
            r_cmd_err <= w_accept & w_bad_reg;
            if (w_accept) begin
                r_reg <= cmd_reg;
                r_dir <= cmd_dir;
                r_cnt <= '0;
                if (cmd_op == STORE && !w_bad_reg) begin
                    r_out_data <= w_rd_data;
                    r_out_last <= 1'b0;
                end
            end else if (w_load_beat) begin
                r_cnt <= w_cnt_nxt;
            end else if (w_store_beat) begin
                r_cnt <= w_cnt_nxt;
                if (w_last) begin
                    r_out_data <= '0;
                    r_out_last <= 1'b0;
                end else begin
                    r_out_data <= w_rd_data;
                    r_out_last <= (w_cnt_nxt == IDX_W'(WIDTH-1));
                end
            end
        end
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign in_ready  = (r_state == ST_LOAD);
    assign out_valid = (r_state == ST_STORE);
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign cmd_err   = r_cmd_err;

endmodule

// File: tb/tb_mat_reg_bank.sv
// Self-checking bench for mat_reg_bank: directed scenarios plus random commands against an array model.
module tb_mat_reg_bank;
    import mat_pkg::*;

    localparam int unsigned NR = 2;
    localparam int unsigned W  = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned RW = 2;
    localparam int unsigned IW = 2;
    localparam int unsigned BW = W * DW;

    logic           clock = 1'b0;
    logic           reset_n = 1'b0;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    MatBankOp_t     cmd_op = LOAD;
    logic [RW-1:0]  cmd_reg = '0;
    MatDir_t        cmd_dir = ROW;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [BW-1:0]  in_data = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [BW-1:0]  out_data;
    logic           out_last;
    logic           cmd_err;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [DW-1:0] model [NR][W][W];

    mat_reg_bank #(
        .NUM_REGS (NR),
        .WIDTH    (W),
        .DATA_W   (DW),
        .REG_W    (RW),
        .IDX_W    (IW)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_reg   (cmd_reg),
        .cmd_dir   (cmd_dir),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .cmd_err   (cmd_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] exp_beat(input int r, input MatDir_t d, input int n);
        logic [BW-1:0] b;
        b = '0;
        for (int k = 0; k < W; k++)
            b[k*DW +: DW] = (d == ROW) ? model[r][n][k] : model[r][k][n];
        return b;
    endfunction

    task automatic model_clear_all();
        for (int r = 0; r < NR; r++)
            for (int i = 0; i < W; i++)
                for (int j = 0; j < W; j++)
                    model[r][i][j] = '0;
    endtask

    task automatic model_op(input MatBankOp_t op, input int r);
        logic [DW-1:0] t [W][W];
        for (int i = 0; i < W; i++)
            for (int j = 0; j < W; j++)
                t[i][j] = model[r][i][j];
        for (int i = 0; i < W; i++) begin
            for (int j = 0; j < W; j++) begin
                case (op)
                    TRANSPOSE: model[r][i][j] = t[j][i];
                    XFLIP:     model[r][i][j] = t[W-1-i][j];
                    YFLIP:     model[r][i][j] = t[i][W-1-j];
                    CLEAR:     model[r][i][j] = '0;
                    default:   ;
                endcase
            end
        end
    endtask

    // Offers a command at a falling edge; returns at the falling edge after acceptance.
    task automatic issue(input MatBankOp_t op, input int r, input MatDir_t d);
        check("cmd_ready_before_issue", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_reg   = RW'(r);
        cmd_dir   = d;
        @(negedge clock);
        cmd_valid = 1'b0;
        check("cmd_err_pulse", cmd_err, (r >= NR));
    endtask

    task automatic single(input MatBankOp_t op, input int r);
        issue(op, r, ROW);
        if (r < NR) model_op(op, r);
    endtask

    task automatic load(input int r, input MatDir_t d, input bit gaps, input bit seq);
        int n;
        int budget;
        logic [DW-1:0] v;
        issue(LOAD, r, d);
        if (r >= NR) begin
            check("bad_load_in_ready", in_ready, 1'b0);
            in_valid = 1'b1;
            @(negedge clock);
            in_valid = 1'b0;
            check("bad_load_err_drop", cmd_err, 1'b0);
            check("bad_load_in_ready2", in_ready, 1'b0);
            return;
        end
        n = 0;
        budget = 0;
        while (n < W && budget < 40) begin
            check("load_in_ready", in_ready, 1'b1);
            if (gaps && budget[0]) begin
                in_valid = 1'b0;
                @(negedge clock);
            end else begin
                in_valid = 1'b1;
                for (int k = 0; k < W; k++) begin
                    v = seq ? DW'(n * W + k) : $urandom;
                    in_data[k*DW +: DW] = v;
                    if (d == ROW) model[r][n][k] = v;
                    else          model[r][k][n] = v;
                end
                @(negedge clock);
                n++;
            end
            budget++;
        end
        in_valid = 1'b0;
        if (n < W) check("load_timeout", 1'b0, 1'b1);
        check("load_done_cmd_ready", cmd_ready, 1'b1);
        check("load_done_in_ready", in_ready, 1'b0);
    endtask

    // stall: 0 = always ready, 1 = random, 2 = not ready for the first three cycles.
    task automatic store(input int r, input MatDir_t d, input int stall);
        int n;
        int cyc;
        logic rdy;
        issue(STORE, r, d);
        if (r >= NR) begin
            check("bad_store_out_valid", out_valid, 1'b0);
            @(negedge clock);
            check("bad_store_err_drop", cmd_err, 1'b0);
            check("bad_store_out_valid2", out_valid, 1'b0);
            return;
        end
        n = 0;
        cyc = 0;
        while (n < W && cyc < 60) begin
            check("store_out_valid", out_valid, 1'b1);
            check("store_out_data", out_data, exp_beat(r, d, n));
            check("store_out_last", out_last, (n == W - 1));
            case (stall)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom_range(0, 1));
                default: rdy = (cyc >= 3);
            endcase
            out_ready = rdy;
            @(negedge clock);
            if (rdy) n++;
            cyc++;
        end
        out_ready = 1'b0;
        if (n < W) check("store_timeout", 1'b0, 1'b1);
        check("store_done_out_valid", out_valid, 1'b0);
        check("store_done_cmd_ready", cmd_ready, 1'b1);
    endtask

    initial begin
        logic [BW-1:0] b;
        model_clear_all();
        reset_n = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_cmd_err", cmd_err, 1'b0);
        reset_n = 1'b1;
        @(negedge clock);

        // Row load, row store, column store with early backpressure.
        load(0, ROW, 1'b0, 1'b1);
        store(0, ROW, 0);
        store(0, COL, 2);

        // Back-to-back transpose and X-flip; absolute expectation on the first beat.
        single(TRANSPOSE, 0);
        single(XFLIP, 0);
        b = {32'd15, 32'd11, 32'd7, 32'd3};
        check("tx_xf_first_beat_model", exp_beat(0, ROW, 0), b);
        store(0, ROW, 0);
        store(1, ROW, 1);

        // Invalid register.
        load(2, ROW, 1'b0, 1'b1);
        store(0, ROW, 0);

        // Reset in the middle of a load.
        issue(LOAD, 0, ROW);
        for (int n = 0; n < 2; n++) begin
            in_valid = 1'b1;
            in_data  = {W*DW/32{$urandom}};
            @(negedge clock);
        end
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        check("midrst_cmd_ready", cmd_ready, 1'b1);
        check("midrst_in_ready", in_ready, 1'b0);
        model_clear_all();
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        store(0, ROW, 0);

        // Gapped load, then Y-flip.
        load(1, ROW, 1'b1, 1'b1);
        single(YFLIP, 1);
        b = {32'd0, 32'd1, 32'd2, 32'd3};
        check("yflip_first_beat_model", exp_beat(1, ROW, 0), b);
        store(1, ROW, 1);

        // Random command mix, including invalid registers.
        for (int t = 0; t < 60; t++) begin
            int r;
            MatBankOp_t op;
            MatDir_t d;
            r  = int'($urandom_range(0, NR));
            op = MatBankOp_t'(3'($urandom_range(0, 5)));
            d  = MatDir_t'(1'($urandom_range(0, 1)));
            case (op)
                LOAD:    load(r, d, 1'($urandom_range(0, 1)), 1'b0);
                STORE:   store(r, d, 1);
                default: single(op, r);
            endcase
        end
        for (int r = 0; r < NR; r++) store(r, ROW, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
